// File: rtl/div_32_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_32_seq: multi-cycle signed 32-bit restoring divider, one quotient bit   |
// | per clock, quotient truncated toward zero, divide-by-zero/overflow flag.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module div_32_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] c_last    = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic             r_sign;
  logic             r_exc;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_start_exc;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;

  // Negating 0x80000000 yields 0x80000000, which read unsigned is exactly 2^31.
  assign w_abs_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_abs_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign w_start_exc = (data_operandB == '0) ||
                       ((data_operandA == c_min_neg) && (data_operandB == {WIDTH{1'b1}}));

  // The remainder stays below the divisor, so only the shifted value needs the extra bit.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_div};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_quo          <= '0;
      r_rem          <= '0;
      r_div          <= '0;
      r_sign         <= 1'b0;
      r_exc          <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_DIV) begin
        r_quo   <= w_abs_a;
        r_rem   <= '0;
        r_div   <= w_abs_b;
        r_sign  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        r_exc   <= w_start_exc;
        r_cnt   <= '0;
        r_state <= S_RUN;
        busy    <= 1'b1;
      end else begin
        case (r_state)
          S_RUN: begin
            // A pending exception spends one cycle here so its latency is two edges.
            if (r_exc) begin
              r_state <= S_DONE;
            end else begin
              r_rem <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
              r_cnt <= r_cnt + 1'b1;
              if (r_cnt == c_last) begin
                r_state <= S_DONE;
              end
            end
          end
          S_DONE: begin
            data_result    <= r_exc ? '0 : (r_sign ? -r_quo : r_quo);
            data_exception <= r_exc;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            r_state        <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
